// File: rtl/sp_fifo_pkg.sv
// Shared types for the single-port-RAM FIFO controller: RAM op encoding,
// arbitration priority states and the RAM depth helper.
package sp_fifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_WR   = 2'd1,
    OP_RD   = 2'd2
  } op_e;

  typedef enum logic {
    PRIO_WR = 1'b0,
    PRIO_RD = 1'b1
  } prio_e;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/sp_fifo_skid.sv
// Two-entry in-order output buffer giving first-word-fall-through on the
// read side of the FIFO controller. Caller never pushes into a full buffer.
module sp_fifo_skid #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [1:0]            count_o,
  output logic [DATA_WIDTH-1:0] head_o
);

  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;

  // NOTE: every variable gets a default before the case, otherwise the
  // unlisted push/pop combinations would infer latches.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = push_data_i;
        else               tail_d = push_data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          head_d = tail_q;
          tail_d = push_data_i;
        end else begin
          head_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together at the edge regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= 2'd0;
    else          cnt_q <= cnt_d;
  end

  // NOTE: data entries carry no reset; the count alone defines validity, so
  // resetting the storage would only cost reset routing.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  assign count_o = cnt_q;
  assign head_o  = head_q;

endmodule

// File: rtl/sp_ram_fifo_ctrl.sv
// FIFO controller time-sharing one synchronous single-port RAM between writes
// and reads. Define SP_FIFO_LEVEL_EN to add the level/almost_full outputs.
module sp_ram_fifo_ctrl
  import sp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
`ifdef SP_FIFO_LEVEL_EN
  ,
  parameter int AF_THRESH  = int'(fifo_depth(ADDR_WIDTH)) - 2
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q
`ifdef SP_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  almost_full
`endif
);

  localparam int                  DEPTH     = int'(fifo_depth(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
  logic                  inflight_q, inflight_d;
  prio_e                 prio_q, prio_d;
  logic                  rst_done_q;

  logic [1:0] skid_cnt;
  logic       full;
  logic       rd_want;
  logic       contention;
  logic       pop;
  op_e        op;

  // A read is only issued if the skid can absorb it together with any read
  // whose data is still on its way back from the RAM.
  always_comb begin
    full       = (ram_cnt_q == DEPTH_CNT);
    rd_want    = (ram_cnt_q != '0) &&
                 (({1'b0, skid_cnt} + {2'b00, inflight_q}) < 3'd2);
    in_ready   = rst_done_q && !full && !(rd_want && (prio_q == PRIO_RD));
    contention = in_valid && rd_want && !full;
  end

  always_comb begin
    op = OP_IDLE;
    if (in_valid && in_ready) op = OP_WR;
    else if (rd_want)         op = OP_RD;
  end

  // Datapath next-state and RAM port drive for the selected op.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    inflight_d = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    case (op)
      OP_WR: begin
        ram_we    = 1'b1;
        ram_addr  = wr_ptr_q;
        wr_ptr_d  = wr_ptr_q + 1'b1;
        ram_cnt_d = ram_cnt_q + 1'b1;
      end
      OP_RD: begin
        ram_addr   = rd_ptr_q;
        rd_ptr_d   = rd_ptr_q + 1'b1;
        ram_cnt_d  = ram_cnt_q - 1'b1;
        inflight_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Arbitration FSM: the owner wins a contended cycle, then ownership flips.
  always_comb begin
    prio_d = prio_q;
    if (contention) prio_d = (prio_q == PRIO_WR) ? PRIO_RD : PRIO_WR;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      prio_q     <= PRIO_WR;
      rst_done_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      prio_q     <= prio_d;
      rst_done_q <= 1'b1;
    end
  end

  assign ram_d = in_data;
  assign pop   = out_valid && out_ready;

  sp_fifo_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (inflight_q),
    .push_data_i (ram_q),
    .pop_i       (pop),
    .count_o     (skid_cnt),
    .head_o      (out_data)
  );

  assign out_valid = (skid_cnt != 2'd0);

`ifdef SP_FIFO_LEVEL_EN
  always_comb begin
    level       = {1'b0, ram_cnt_q} + (ADDR_WIDTH+2)'(inflight_q) +
                  (ADDR_WIDTH+2)'(skid_cnt);
    almost_full = (level >= (ADDR_WIDTH+2)'(AF_THRESH));
  end
`endif

endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// Scoreboard bench for sp_ram_fifo_ctrl with a 1-cycle registered-read RAM
// model, depth 4, 8-bit data.
module tb_sp_ram_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk       = 1'b0;
  logic          reset_n   = 1'b0;
  logic          in_valid  = 1'b0;
  logic [DW-1:0] in_data   = '0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_d;
  logic [DW-1:0] ram_q;
`ifdef SP_FIFO_LEVEL_EN
  logic [AW+1:0] level;
  logic          almost_full;
`endif

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] mem[4];
  int            wr_cnt = 0;
  logic          rec = 1'b0;
  logic          we_hist[$];

  always #5 clk = ~clk;

  sp_ram_fifo_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_d       (ram_d),
    .ram_q       (ram_q)
`ifdef SP_FIFO_LEVEL_EN
    ,
    .level       (level),
    .almost_full (almost_full)
`endif
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_d;
    ram_q <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: output scoreboard, write-address sequence, op history.
  always @(negedge clk) begin
    if (!reset_n) begin
      wr_cnt = 0;
    end else begin
      if (ram_we) begin
        check("wr_addr", 32'(ram_addr), 32'(wr_cnt % 4));
        wr_cnt++;
      end
      if (rec) we_hist.push_back(ram_we);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
        else                check("out_data", 32'(out_data), 32'(sb.pop_front()));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [DW-1:0] d);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < 64 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("send_accept", 32'(acc), 32'd1);
    if (acc) sb.push_back(d);
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) break;
    end
    check({name, "_left"}, 32'(sb.size()), 32'd0);
    check({name, "_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset held with upstream pushing.
    in_valid  = 1'b1;
    in_data   = 8'hEE;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    #2 reset_n = 1'b1;
    #1 check("rel_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 check("rdy_after_edge", 32'(in_ready), 32'd1);
    in_valid = 1'b0;

    // Latency through an empty FIFO.
    @(posedge clk);
    #1 in_valid = 1'b1;
    in_data = 8'h5A;
    @(negedge clk);
    check("lat_accept", 32'(in_ready), 32'd1);
    sb.push_back(8'h5A);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("lat_k", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_k1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_k2_valid", 32'(out_valid), 32'd1);
    check("lat_k2_data", 32'(out_data), 32'h5A);
    wait_drain("lat");

    // Fill to DEPTH+2 with the output stalled, then drain in order.
    @(posedge clk);
    #1 out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(8'h10 + 8'(i));
    in_valid = 1'b1;
    in_data  = 8'h16;
    repeat (4) begin
      @(negedge clk);
      check("fill_full_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain("fill");

    // Sustained contention: writes and reads alternate on the one port.
    @(posedge clk);
    #1 rec = 1'b1;
    for (int i = 0; i < 16; i++) send(8'h30 + 8'(i));
    rec = 1'b0;
    for (int i = 4; i < we_hist.size(); i++)
      check("we_alternate", 32'(we_hist[i]), 32'(!we_hist[i-1]));
    check("throughput", 32'(we_hist.size() <= 34), 32'd1);
    wait_drain("contention");

    // Pointer wrap: 20 words through depth 4.
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) send(8'h60 + 8'(i));
    wait_drain("wrap");

    // Asynchronous reset with three words stored.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(8'hA1);
    send(8'hA2);
    send(8'hA3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    #1 check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_we", 32'(ram_we), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    check("mid_rst_we_held", 32'(ram_we), 32'd0);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      check("post_rst_empty", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(8'hA5);
    wait_drain("recover");
    repeat (3) begin
      @(negedge clk);
      check("recover_empty", 32'(out_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
